// File: rtl/fpu_sequencer_pkg.sv
// fpu_sequencer_pkg: opcodes, unit indices, flag/fclass bit positions and helpers
package fpu_sequencer_pkg;

    typedef enum logic [4:0] {
        OP_FADD    = 5'd0,
        OP_FSUB    = 5'd1,
        OP_FMUL    = 5'd2,
        OP_FDIV    = 5'd3,
        OP_FCVT_SW = 5'd4,
        OP_FCVT_WS = 5'd5,
        OP_FSGNJ   = 5'd6,
        OP_FSGNJN  = 5'd7,
        OP_FEQ     = 5'd8,
        OP_FLT     = 5'd9,
        OP_FLE     = 5'd10,
        OP_FSGNJX  = 5'd11,
        OP_FMIN    = 5'd12,
        OP_FMAX    = 5'd13,
        OP_FCLASS  = 5'd14
    } fpu_op_t;

    localparam int NU = 5;
    localparam logic [2:0] UNIT_ADD = 3'd0;
    localparam logic [2:0] UNIT_MUL = 3'd1;
    localparam logic [2:0] UNIT_DIV = 3'd2;
    localparam logic [2:0] UNIT_I2F = 3'd3;
    localparam logic [2:0] UNIT_F2I = 3'd4;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    function automatic logic is_slow(logic [4:0] op);
        return op <= 5'(OP_FCVT_WS);
    endfunction

    function automatic logic [2:0] op_unit(logic [4:0] op);
        case (op)
            OP_FMUL:    return UNIT_MUL;
            OP_FDIV:    return UNIT_DIV;
            OP_FCVT_SW: return UNIT_I2F;
            OP_FCVT_WS: return UNIT_F2I;
            default:    return UNIT_ADD;
        endcase
    endfunction

    // Positive quiet NaN with only the mantissa MSB set; callers truncate to their width.
    function automatic logic [63:0] canon_nan(int exp_w, int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// fpu_sequencer_if: core-side request/response bus of the FPU sequencer
interface fpu_sequencer_if #(parameter int W = 32);
    logic [4:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         in_stb;
    logic         in_ack;
    logic [W-1:0] out;
    logic [4:0]   flags;
    logic         err;
    logic         out_stb;
    logic         out_ack;
    logic         busy;

    modport master (
        output op, in1, in2, in_stb, out_ack,
        input  in_ack, out, flags, err, out_stb, busy
    );

    modport slave (
        input  op, in1, in2, in_stb, out_ack,
        output in_ack, out, flags, err, out_stb, busy
    );
endinterface

// File: rtl/fpu_sequencer_fast_ops.sv
// fpu_sequencer_fast_ops: single-cycle compare, sign-inject, min/max and fclass
module fpu_sequencer_fast_ops
    import fpu_sequencer_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         nv
);
    localparam logic [W-1:0] CANON = W'(canon_nan(EXP_W, MAN_W));

    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;
    logic a_s, b_s, a_nan, b_nan, a_snan, b_snan, a_inf, a_zero, b_zero, a_sub, a_norm;
    logic any_nan, any_snan, both_zero, lt_ord, lt, eq;
    logic [9:0] cls;

    assign a_s       = a[W-1];
    assign b_s       = b[W-1];
    assign a_e       = a[W-2:MAN_W];
    assign b_e       = b[W-2:MAN_W];
    assign a_m       = a[MAN_W-1:0];
    assign b_m       = b[MAN_W-1:0];
    assign a_nan     = &a_e && |a_m;
    assign b_nan     = &b_e && |b_m;
    assign a_snan    = a_nan && !a_m[MAN_W-1];
    assign b_snan    = b_nan && !b_m[MAN_W-1];
    assign a_inf     = &a_e && !(|a_m);
    assign a_zero    = !(|a_e) && !(|a_m);
    assign b_zero    = !(|b_e) && !(|b_m);
    assign a_sub     = !(|a_e) && |a_m;
    assign a_norm    = |a_e && !(&a_e);
    assign any_nan   = a_nan || b_nan;
    assign any_snan  = a_snan || b_snan;
    assign both_zero = a_zero && b_zero;
    // Total order on non-NaN values where -0 sorts below +0 (what min/max need).
    assign lt_ord    = a_s != b_s ? a_s : (a_s ? a[W-2:0] > b[W-2:0] : a[W-2:0] < b[W-2:0]);
    assign lt        = lt_ord && !both_zero;
    assign eq        = a == b || both_zero;

    // Build the fclass mask for operand a
    always_comb begin
        cls = '0;
        cls[FCLASS_NEG_INF]  = a_s && a_inf;
        cls[FCLASS_NEG_NORM] = a_s && a_norm;
        cls[FCLASS_NEG_SUB]  = a_s && a_sub;
        cls[FCLASS_NEG_ZERO] = a_s && a_zero;
        cls[FCLASS_POS_ZERO] = !a_s && a_zero;
        cls[FCLASS_POS_SUB]  = !a_s && a_sub;
        cls[FCLASS_POS_NORM] = !a_s && a_norm;
        cls[FCLASS_POS_INF]  = !a_s && a_inf;
        cls[FCLASS_SNAN]     = a_snan;
        cls[FCLASS_QNAN]     = a_nan && a_m[MAN_W-1];
    end

    // Select the fast-op result and invalid flag; unknown opcodes give 0 with NV
    always_comb begin
        result = '0;
        nv     = 1'b0;
        case (op)
            OP_FSGNJ:  result = {b_s, a[W-2:0]};
            OP_FSGNJN: result = {~b_s, a[W-2:0]};
            OP_FSGNJX: result = {a_s ^ b_s, a[W-2:0]};
            OP_FEQ: begin
                result = W'(!any_nan && eq);
                nv     = any_snan;
            end
            OP_FLT: begin
                result = W'(!any_nan && lt);
                nv     = any_nan;
            end
            OP_FLE: begin
                result = W'(!any_nan && (lt || eq));
                nv     = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                result = a_nan && b_nan ? CANON :
                         a_nan ? b :
                         b_nan ? a :
                         (lt_ord ^ (op == OP_FMAX)) ? a : b;
                nv     = any_snan;
            end
            OP_FCLASS: result = W'(cls);
            default:   nv = 1'b1;
        endcase
    end
endmodule

// File: rtl/fpu_sequencer.sv
// fpu_sequencer: accepts one FP op, runs fast ops locally, dispatches slow ops to units
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int TIMEOUT = 1024,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    fpu_sequencer_if.slave    bus,
    output logic [W-1:0]      unit_a,
    output logic [W-1:0]      unit_b,
    output logic [NU-1:0]     unit_stb,
    input  logic [NU-1:0]     unit_ack,
    input  logic [NU*W-1:0]   unit_z,
    input  logic [NU-1:0]     unit_z_stb,
    output logic [NU-1:0]     unit_z_ack
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] CANON = W'(canon_nan(EXP_W, MAN_W));

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state;
    logic [4:0]    op_q;
    logic [2:0]    u_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  fast_res;
    logic          fast_nv;
    logic          wd_expired;

    // unit_a/unit_b hold the captured operands; fast ops never see the fsub sign flip
    fpu_sequencer_fast_ops #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_fast (
        .op     (op_q),
        .a      (unit_a),
        .b      (unit_b),
        .result (fast_res),
        .nv     (fast_nv)
    );

    assign wd_expired = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    assign bus.busy   = state != S_IDLE;

    // Request/response FSM with operand capture, unit dispatch and watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            u_q         <= '0;
            cnt         <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            unit_stb    <= '0;
            unit_z_ack  <= '0;
            bus.in_ack  <= 1'b0;
            bus.out     <= '0;
            bus.flags   <= '0;
            bus.err     <= 1'b0;
            bus.out_stb <= 1'b0;
        end else begin
            bus.in_ack <= 1'b0;
            unit_z_ack <= '0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (bus.in_stb) begin
                        op_q       <= bus.op;
                        u_q        <= op_unit(bus.op);
                        unit_a     <= bus.in1;
                        unit_b     <= bus.op == OP_FSUB ? {~bus.in2[W-1], bus.in2[W-2:0]} : bus.in2;
                        bus.in_ack <= 1'b1;
                        if (is_slow(bus.op)) begin
                            unit_stb <= NU'(1) << op_unit(bus.op);
                            state    <= S_ISSUE;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    bus.out     <= fast_res;
                    bus.flags   <= 5'(fast_nv) << FLAG_NV;
                    bus.err     <= 1'b0;
                    bus.out_stb <= 1'b1;
                    state       <= S_RESP;
                end
                S_ISSUE, S_WAIT: begin
                    if (wd_expired) begin
                        unit_stb    <= '0;
                        bus.out     <= CANON;
                        bus.flags   <= '0;
                        bus.err     <= 1'b1;
                        bus.out_stb <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (state == S_ISSUE) begin
                            if (unit_ack[u_q]) begin
                                unit_stb <= '0;
                                state    <= S_WAIT;
                            end
                        end else if (unit_z_stb[u_q]) begin
                            unit_z_ack[u_q] <= 1'b1;
                            bus.out         <= unit_z[u_q*W +: W];
                            bus.flags       <= '0;
                            bus.err         <= 1'b0;
                            bus.out_stb     <= 1'b1;
                            state           <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.out_ack) begin
                        bus.out_stb <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_sequencer.sv
// tb_fpu_sequencer: table-driven fast ops plus hand sequences for units, watchdog and reset
module tb_fpu_sequencer;
    import fpu_sequencer_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] out;
        logic [4:0]  flags;
        logic        err;
    } res_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic [4:0]  flags;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [W-1:0]    unit_a, unit_b;
    logic [NU-1:0]   unit_stb, unit_z_ack;
    logic [NU-1:0]   unit_ack = '0;
    logic [NU-1:0]   unit_z_stb = '0;
    logic [NU*W-1:0] unit_z = '0;

    res_t          exp_q[$];
    vec_t          vecs[$];
    int            total = 0;
    int            bad = 0;
    logic [NU-1:0] stb_seen;
    int            zack_n;

    fpu_sequencer_if #(.W(W)) bus ();

    fpu_sequencer #(.EXP_W(8), .MAN_W(23), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_stb   (unit_stb),
        .unit_ack   (unit_ack),
        .unit_z     (unit_z),
        .unit_z_stb (unit_z_stb),
        .unit_z_ack (unit_z_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        stb_seen |= unit_stb;
        zack_n += $countones(unit_z_ack);
    endtask

    task automatic check_idle(string name);
        check({name, " in_ack"}, bus.in_ack, 0);
        check({name, " out_stb"}, bus.out_stb, 0);
        check({name, " busy"}, bus.busy, 0);
        check({name, " out"}, bus.out, 0);
        check({name, " flags"}, bus.flags, 0);
        check({name, " err"}, bus.err, 0);
        check({name, " unit_stb"}, unit_stb, 0);
        check({name, " unit_z_ack"}, unit_z_ack, 0);
        check({name, " unit_a"}, unit_a, 0);
    endtask

    task automatic issue(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b);
        bus.op = op;
        bus.in1 = a;
        bus.in2 = b;
        bus.in_stb = 1'b1;
        tick();
        bus.in_stb = 1'b0;
        check({name, " in_ack"}, bus.in_ack, 1);
    endtask

    task automatic wait_out(string name, int max);
        int n = 0;
        while (!bus.out_stb && n < max) begin
            tick();
            n++;
        end
        check({name, " out_stb within bound"}, bus.out_stb, 1);
    endtask

    task automatic compare_head(string name);
        res_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: result with empty scoreboard, got %0h", name, bus.out);
            return;
        end
        e = exp_q.pop_front();
        check({name, " out"}, bus.out, e.out);
        check({name, " flags"}, bus.flags, e.flags);
        check({name, " err"}, bus.err, e.err);
    endtask

    task automatic collect(string name);
        compare_head(name);
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        check({name, " out_stb cleared"}, bus.out_stb, 0);
        check({name, " busy cleared"}, bus.busy, 0);
    endtask

    task automatic unit_serve(string name, int u, logic [31:0] z, int delay);
        unit_ack[u] = 1'b1;
        tick();
        unit_ack[u] = 1'b0;
        check({name, " unit_stb dropped"}, unit_stb, 0);
        repeat (delay) begin
            tick();
            check({name, " no early out_stb"}, bus.out_stb, 0);
        end
        unit_z[u*W +: W] = z;
        unit_z_stb[u] = 1'b1;
        tick();
        unit_z_stb[u] = 1'b0;
        check({name, " unit_z_ack pulse"}, unit_z_ack, NU'(1) << u);
        check({name, " out_stb"}, bus.out_stb, 1);
        tick();
        check({name, " unit_z_ack one cycle"}, unit_z_ack, 0);
    endtask

    initial begin
        vecs.push_back('{OP_FLT,    32'h7F800001, 32'h3F800000, 32'h0,        5'b10000});
        vecs.push_back('{OP_FEQ,    32'h7FC00000, 32'h7FC00000, 32'h0,        5'b00000});
        vecs.push_back('{OP_FLE,    32'h80000000, 32'h00000000, 32'h1,        5'b00000});
        vecs.push_back('{OP_FMIN,   32'h7FC00000, 32'hBF800000, 32'hBF800000, 5'b00000});
        vecs.push_back('{OP_FMAX,   32'h80000000, 32'h00000000, 32'h00000000, 5'b00000});
        vecs.push_back('{OP_FCLASS, 32'hFF800000, 32'h0,        32'h001,      5'b00000});
        vecs.push_back('{OP_FEQ,    32'h00000000, 32'h80000000, 32'h1,        5'b00000});
        vecs.push_back('{OP_FEQ,    32'h7F800001, 32'h3F800000, 32'h0,        5'b10000});
        vecs.push_back('{OP_FLT,    32'hBF800000, 32'h3F800000, 32'h1,        5'b00000});
        vecs.push_back('{OP_FLT,    32'hC0000000, 32'hBF800000, 32'h1,        5'b00000});
        vecs.push_back('{OP_FLE,    32'h40000000, 32'h3F800000, 32'h0,        5'b00000});
        vecs.push_back('{OP_FLT,    32'h80000000, 32'h00000000, 32'h0,        5'b00000});
        vecs.push_back('{OP_FSGNJ,  32'h3F800000, 32'h80000000, 32'hBF800000, 5'b00000});
        vecs.push_back('{OP_FSGNJN, 32'h3F800000, 32'h80000000, 32'h3F800000, 5'b00000});
        vecs.push_back('{OP_FSGNJX, 32'hBF800000, 32'h80000000, 32'h3F800000, 5'b00000});
        vecs.push_back('{OP_FMIN,   32'h7F800001, 32'h7FC00000, 32'h7FC00000, 5'b10000});
        vecs.push_back('{OP_FMAX,   32'h3F800000, 32'h7F800001, 32'h3F800000, 5'b10000});
        vecs.push_back('{OP_FMIN,   32'h00000000, 32'h80000000, 32'h80000000, 5'b00000});
        vecs.push_back('{OP_FMAX,   32'hC0000000, 32'hBF800000, 32'hBF800000, 5'b00000});
        vecs.push_back('{OP_FCLASS, 32'h7F800001, 32'h0,        32'h100,      5'b00000});
        vecs.push_back('{OP_FCLASS, 32'h00000001, 32'h0,        32'h020,      5'b00000});
        vecs.push_back('{OP_FCLASS, 32'h3F800000, 32'h0,        32'h040,      5'b00000});
        vecs.push_back('{OP_FCLASS, 32'h80000000, 32'h0,        32'h008,      5'b00000});
        vecs.push_back('{OP_FCLASS, 32'h7FC00000, 32'h0,        32'h200,      5'b00000});
        vecs.push_back('{5'd20,     32'h3F800000, 32'h3F800000, 32'h0,        5'b10000});
        vecs.push_back('{5'd31,     32'h12345678, 32'h3F800000, 32'h0,        5'b10000});

        bus.op = '0;
        bus.in1 = '0;
        bus.in2 = '0;
        bus.in_stb = 1'b0;
        bus.out_ack = 1'b0;
        stb_seen = '0;
        zack_n = 0;
        #1;
        check_idle("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_idle("after reset");

        foreach (vecs[i]) begin
            string nm = $sformatf("vec%0d op%0d", i, vecs[i].op);
            issue(nm, vecs[i].op, vecs[i].a, vecs[i].b);
            exp_q.push_back('{vecs[i].out, vecs[i].flags, 1'b0});
            check({nm, " busy"}, bus.busy, 1);
            tick();
            check({nm, " out_stb at accept+2"}, bus.out_stb, 1);
            collect(nm);
        end

        stb_seen = '0;
        zack_n = 0;
        issue("fmul", OP_FMUL, 32'h40000000, 32'h40400000);
        check("fmul unit_stb", unit_stb, 5'b00010);
        check("fmul unit_a", unit_a, 32'h40000000);
        check("fmul unit_b", unit_b, 32'h40400000);
        unit_z[0 +: W] = 32'hDEADBEEF;
        unit_z_stb[0] = 1'b1;
        exp_q.push_back('{32'h40C00000, 5'b0, 1'b0});
        unit_serve("fmul", 1, 32'h40C00000, 6);
        unit_z_stb[0] = 1'b0;
        collect("fmul");
        check("fmul only unit 1 strobed", stb_seen, 5'b00010);
        check("fmul z_ack pulse count", zack_n, 1);

        issue("fsub", OP_FSUB, 32'h3F800000, 32'h3F800000);
        check("fsub unit_stb", unit_stb, 5'b00001);
        check("fsub unit_a", unit_a, 32'h3F800000);
        check("fsub unit_b flipped", unit_b, 32'hBF800000);
        exp_q.push_back('{32'h00000000, 5'b0, 1'b0});
        unit_serve("fsub", 0, 32'h00000000, 2);
        collect("fsub");

        issue("fdiv timeout", OP_FDIV, 32'h3F800000, 32'h40000000);
        check("fdiv unit_stb", unit_stb, 5'b00100);
        repeat (15) tick();
        check("fdiv no out_stb at ISSUE cycle 16", bus.out_stb, 0);
        check("fdiv unit_stb still high", unit_stb, 5'b00100);
        tick();
        check("fdiv out_stb after watchdog", bus.out_stb, 1);
        check("fdiv unit_stb low after watchdog", unit_stb, 0);
        repeat (3) tick();
        check("fdiv busy until out_ack", bus.busy, 1);
        check("fdiv unit_stb stays low", unit_stb, 0);
        exp_q.push_back('{32'h7FC00000, 5'b0, 1'b1});
        collect("fdiv timeout");

        issue("fadd reset", OP_FADD, 32'h3F800000, 32'h40000000);
        unit_ack[0] = 1'b1;
        tick();
        unit_ack[0] = 1'b0;
        check("fadd in WAIT busy", bus.busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async reset in WAIT");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check_idle("released");

        issue("fadd post-reset", OP_FADD, 32'h3F800000, 32'h3F800000);
        check("fadd unit_stb", unit_stb, 5'b00001);
        check("fadd unit_b unflipped", unit_b, 32'h3F800000);
        exp_q.push_back('{32'h40000000, 5'b0, 1'b0});
        unit_serve("fadd", 0, 32'h40000000, 3);
        collect("fadd post-reset");

        issue("hold fle", OP_FLE, 32'h80000000, 32'h00000000);
        exp_q.push_back('{32'h1, 5'b0, 1'b0});
        wait_out("hold fle", 4);
        bus.op = OP_FEQ;
        bus.in_stb = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hold c%0d in_ack", k), bus.in_ack, 0);
            check($sformatf("hold c%0d out", k), bus.out, 32'h1);
            check($sformatf("hold c%0d flags", k), bus.flags, 0);
            check($sformatf("hold c%0d out_stb", k), bus.out_stb, 1);
        end
        compare_head("hold fle");
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;
        check("hold leave RESP in_ack", bus.in_ack, 0);
        check("hold leave RESP out_stb", bus.out_stb, 0);
        tick();
        bus.in_stb = 1'b0;
        check("back-to-back in_ack", bus.in_ack, 1);
        exp_q.push_back('{32'h1, 5'b0, 1'b0});
        wait_out("back-to-back feq", 4);
        collect("back-to-back feq");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
